// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constants for the add/sub operand loader
package addsub_pkg;

    typedef enum logic [2:0] {
        CMD   = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        ISSUE = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam int CMD_SUB_BIT     = 0;
    localparam int CMD_CHAIN_BIT   = 1;
    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/addsub_flag_calc.sv
// rtl/addsub_flag_calc.sv - carry (add) or borrow (sub) flag from the latched operands
module addsub_flag_calc
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             op_sub_i,
    output logic             flag_o
);

    logic             carry;
    logic [WIDTH-1:0] unused_sum;

    // Add: carry out of the widened sum. Sub (op_b - op_a): borrow when op_a > op_b.
    always_comb begin
        {carry, unused_sum} = {1'b0, op_a_i} + {1'b0, op_b_i};
        flag_o              = op_sub_i ? (op_a_i > op_b_i) : carry;
    end

endmodule

// File: rtl/addsub_operand_loader.sv
// rtl/addsub_operand_loader.sv - frame collector and sequencer for the add/sub stage (optional ADDSUB_LOADER_CHAIN_EN)
module addsub_operand_loader
    import addsub_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_sub,
    output logic             op_valid,
    input  logic             op_ready,
    input  logic [WIDTH-1:0] res_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_flag,
    input  logic             out_ready,
    output logic             err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_sub_q, op_sub_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_flag_q, out_flag_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             xfer;
    logic             flag;

    addsub_flag_calc #(.WIDTH(WIDTH)) u_flag (
        .op_a_i   (op_a_q),
        .op_b_i   (op_b_q),
        .op_sub_i (op_sub_q),
        .flag_o   (flag)
    );

    // State and datapath registers; reset discards any partial frame or pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CMD;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_sub_q   <= 1'b0;
            out_data_q <= '0;
            out_flag_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_sub_q   <= op_sub_d;
            out_data_q <= out_data_d;
            out_flag_q <= out_flag_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next state, operand latching, result capture and inter-byte timeout.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_sub_d   = op_sub_q;
        out_data_d = out_data_q;
        out_flag_d = out_flag_q;
        err_d      = err_q;
        cnt_d      = '0;
        xfer       = in_valid & in_ready;
        case (state_q)
            CMD: begin
                if (xfer) begin
                    op_sub_d = in_data[CMD_SUB_BIT];
                    err_d    = 1'b0;
`ifdef ADDSUB_LOADER_CHAIN_EN
                    if (in_data[CMD_CHAIN_BIT]) begin
                        op_a_d  = out_data_q;
                        state_d = GET_B;
                    end else begin
                        state_d = GET_A;
                    end
`else
                    state_d  = GET_A;
`endif
                end
            end
            GET_A, GET_B: begin
                if (xfer) begin
                    if (state_q == GET_A) begin
                        op_a_d  = in_data;
                        state_d = GET_B;
                    end else begin
                        op_b_d  = in_data;
                        state_d = ISSUE;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // This idle cycle brings the count to TIMEOUT: abort the frame.
                    err_d   = 1'b1;
                    state_d = CMD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ISSUE: begin
                if (op_ready) begin
                    out_data_d = res_in;
                    out_flag_d = flag;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_d = CMD;
                end
            end
            default: state_d = CMD;
        endcase
    end

    // Handshake outputs decoded from the current state only.
    always_comb begin
        in_ready  = (state_q == CMD) || (state_q == GET_A) || (state_q == GET_B);
        op_valid  = (state_q == ISSUE);
        out_valid = (state_q == RESP);
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_sub   = op_sub_q;
    assign out_data = out_data_q;
    assign out_flag = out_flag_q;
    assign err      = err_q;

endmodule

// File: tb/tb_addsub_operand_loader.sv
// tb/tb_addsub_operand_loader.sv - directed self-checking bench for addsub_operand_loader
module tb_addsub_operand_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] op_a, op_b;
    logic       op_sub, op_valid;
    logic       op_ready = 1'b1;
    logic [7:0] res_in;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_flag;
    logic       out_ready = 1'b1;
    logic       err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural add/sub stage fed by the loader's operands.
    assign res_in = op_sub ? (op_b - op_a) : (op_a + op_b);

    addsub_operand_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .res_in    (res_in),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_flag  (out_flag),
        .out_ready (out_ready),
        .err       (err)
    );

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 16 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_byte_%02h in_ready=%b required=1", b, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (op_valid !== 1'b0)  begin bad++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if ({op_a, op_b, op_sub, out_data, out_flag} !== 26'd0) begin
            bad++; $display("FAIL reset_regs got=%h/%h/%b/%h/%b exp=0", op_a, op_b, op_sub, out_data, out_flag);
        end
    endtask

    task automatic test_add;
        out_ready = 1'b1; op_ready = 1'b1;
        send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
        total++; if (op_valid !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL add_issue op_valid=%b out_valid=%b in_ready=%b exp=1/0/0", op_valid, out_valid, in_ready);
        end
        total++; if (op_a !== 8'h12 || op_b !== 8'h34 || op_sub !== 1'b0) begin
            bad++; $display("FAIL add_operands got=%h/%h/%b exp=12/34/0", op_a, op_b, op_sub);
        end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h46 || out_flag !== 1'b0) begin
            bad++; $display("FAIL add_result valid=%b data=%h flag=%b exp=1/46/0", out_valid, out_data, out_flag);
        end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL add_one_cycle out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_sub;
        logic [7:0] va [2];
        logic [7:0] vb [2];
        logic [7:0] vr [2];
        logic       vf [2];
        va[0] = 8'h05; vb[0] = 8'h03; vr[0] = 8'hFE; vf[0] = 1'b1;
        va[1] = 8'h03; vb[1] = 8'h05; vr[1] = 8'h02; vf[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            send_byte(8'h01); send_byte(va[k]); send_byte(vb[k]);
            total++; if (op_sub !== 1'b1) begin bad++; $display("FAIL sub%0d_mode got=%b exp=1", k, op_sub); end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_data !== vr[k] || out_flag !== vf[k]) begin
                bad++; $display("FAIL sub%0d_result valid=%b data=%h flag=%b exp=1/%h/%b", k, out_valid, out_data, out_flag, vr[k], vf[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send_byte(8'h00); send_byte(8'hF0); send_byte(8'h20);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== 8'h10 || out_flag !== 1'b1 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d valid=%b data=%h flag=%b in_ready=%b exp=1/10/1/0", i, out_valid, out_data, out_flag, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h10 || in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_cycle6 valid=%b data=%h in_ready=%b exp=1/10/0", out_valid, out_data, in_ready);
        end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_timeout;
        out_ready = 1'b1;
        send_byte(8'h00); send_byte(8'h11);
        repeat (254) @(posedge clk);
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL to_early err=%b exp=0 after 254 idle", err); end
        @(posedge clk); #1;
        total++; if (err !== 1'b1 || in_ready !== 1'b1 || op_valid !== 1'b0) begin
            bad++; $display("FAIL to_abort err=%b in_ready=%b op_valid=%b exp=1/1/0", err, in_ready, op_valid);
        end
        send_byte(8'h00);
        total++; if (err !== 1'b0 || op_valid !== 1'b0) begin
            bad++; $display("FAIL to_cmd err=%b op_valid=%b exp=0/0", err, op_valid);
        end
        send_byte(8'h01); send_byte(8'h02);
        total++; if (op_a !== 8'h01 || op_b !== 8'h02 || op_valid !== 1'b1) begin
            bad++; $display("FAIL to_frame_ops got=%h/%h/%b exp=01/02/1", op_a, op_b, op_valid);
        end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h03) begin
            bad++; $display("FAIL to_frame_result valid=%b data=%h exp=1/03", out_valid, out_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_issue;
        op_ready = 1'b0;
        send_byte(8'h01); send_byte(8'h09); send_byte(8'h04);
        total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL rmi_issue op_valid=%b exp=1", op_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        op_ready = 1'b1;
        total++; if (op_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0 || op_a !== 8'h00) begin
            bad++; $display("FAIL rmi_after op_valid=%b out_valid=%b in_ready=%b err=%b op_a=%h exp=0/0/1/0/00", op_valid, out_valid, in_ready, err, op_a);
        end
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmi_no_output out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_chain;
        send_byte(8'h00); send_byte(8'h10); send_byte(8'h05);
        @(posedge clk); #1;
        total++; if (out_data !== 8'h15) begin bad++; $display("FAIL chain_first data=%h exp=15", out_data); end
        @(posedge clk); #1;
`ifdef ADDSUB_LOADER_CHAIN_EN
        send_byte(8'h02); send_byte(8'h07);
        total++; if (op_valid !== 1'b1 || op_a !== 8'h15 || op_b !== 8'h07 || op_sub !== 1'b0) begin
            bad++; $display("FAIL chain_ops valid=%b got=%h/%h/%b exp=1/15/07/0", op_valid, op_a, op_b, op_sub);
        end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h1C) begin
            bad++; $display("FAIL chain_result valid=%b data=%h exp=1/1C", out_valid, out_data);
        end
`else
        send_byte(8'h02); send_byte(8'h07);
        total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL nochain_wait op_valid=%b exp=0", op_valid); end
        send_byte(8'h01);
        total++; if (op_valid !== 1'b1 || op_a !== 8'h07 || op_b !== 8'h01 || op_sub !== 1'b0) begin
            bad++; $display("FAIL nochain_ops valid=%b got=%h/%h/%b exp=1/07/01/0", op_valid, op_a, op_b, op_sub);
        end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h08) begin
            bad++; $display("FAIL nochain_result valid=%b data=%h exp=1/08", out_valid, out_data);
        end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_timeout();
        test_reset_mid_issue();
        test_chain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
